// File: rtl/l1_l2_arbiter_pkg.sv
// Shared types for the L1 I/D to L2 port arbiter.
package l1_l2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/l1_l2_arbiter_if.sv
// Bundle of the L1 I-cache, L1 D-cache and L2 port signals around the arbiter.
// slave: the arbiter's view; master: the surrounding caches' view.
interface l1_l2_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic                  i_read;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_resp;
    logic [LINE_W-1:0]     i_rdata;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_W-1:0]     d_addr;
    logic [LINE_W-1:0]     d_wdata;
    logic [LINE_W/8-1:0]   d_mbe;
    logic                  d_resp;
    logic [LINE_W-1:0]     d_rdata;

    logic                  l2_read;
    logic                  l2_write;
    logic [ADDR_W-1:0]     l2_addr;
    logic [LINE_W-1:0]     l2_wdata;
    logic [LINE_W/8-1:0]   l2_mbe;
    logic                  l2_resp;
    logic [LINE_W-1:0]     l2_rdata;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_mbe, l2_resp, l2_rdata,
        output i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_addr, l2_wdata, l2_mbe
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_mbe, l2_resp, l2_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_addr, l2_wdata, l2_mbe
    );
endinterface

// File: rtl/l1_l2_arb_req_reg.sv
// Registered copy of the granted L1 request; the L2 side is driven only from here.
module l1_l2_arb_req_reg
    import l1_l2_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_clear,
    input  logic                i_rd,
    input  logic                i_wr,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [LINE_W-1:0]   i_wdata,
    input  logic [LINE_W/8-1:0] i_mbe,
    output logic                o_rd,
    output logic                o_wr,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [LINE_W-1:0]   o_wdata,
    output logic [LINE_W/8-1:0] o_mbe
);

    // Clear wins over load; clear and load never coincide in normal operation.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            o_rd    <= 1'b0;
            o_wr    <= 1'b0;
            o_addr  <= '0;
            o_wdata <= '0;
            o_mbe   <= '0;
        end else if (i_load) begin
            o_rd    <= i_rd;
            o_wr    <= i_wr;
            o_addr  <= i_addr;
            o_wdata <= i_wdata;
            o_mbe   <= i_mbe;
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing the single L2 port between the L1 I-cache and D-cache.
module l1_l2_arbiter
    import l1_l2_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic             clk,
    input  logic             rst,
    l1_l2_arbiter_if.slave   bus
);

    localparam int unsigned MBE_W = LINE_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    grant_t              r_last_grant;

    logic                w_idle;
    logic                w_req_i;
    logic                w_req_d;
    logic                w_gnt_i;
    logic                w_gnt_d;
    logic                w_clear;

    logic                w_ld_rd;
    logic                w_ld_wr;
    logic [ADDR_W-1:0]   w_ld_addr;
    logic [LINE_W-1:0]   w_ld_wdata;
    logic [MBE_W-1:0]    w_ld_mbe;

    logic                w_rd;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [LINE_W-1:0]   w_wdata;
    logic [MBE_W-1:0]    w_mbe;

    assign w_idle  = (r_state == IDLE);
    assign w_req_i = bus.i_read;
    assign w_req_d = bus.d_read | bus.d_write;

    // Grants only happen in IDLE, so a request is never re-granted in its own resp cycle.
    assign w_gnt_i = w_idle & w_req_i & (~w_req_d | (r_last_grant == GNT_D));
    assign w_gnt_d = w_idle & w_req_d & (~w_req_i | (r_last_grant == GNT_I));

    // A simultaneous d_read/d_write is treated as a write.
    assign w_ld_rd    = w_gnt_i ? 1'b1 : (bus.d_read & ~bus.d_write);
    assign w_ld_wr    = w_gnt_i ? 1'b0 : bus.d_write;
    assign w_ld_addr  = w_gnt_i ? bus.i_addr : bus.d_addr;
    assign w_ld_wdata = w_gnt_i ? '0 : bus.d_wdata;
    assign w_ld_mbe   = w_gnt_i ? '0 : bus.d_mbe;

    // Next-state selection and end-of-transaction clear.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_i)      w_state_nxt = SERVE_I;
                else if (w_gnt_d) w_state_nxt = SERVE_D;
            end
            SERVE_I, SERVE_D: begin
                if (bus.l2_resp) begin
                    w_state_nxt = IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Last-grant flop; reset to D so the I-cache wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)          r_last_grant <= GNT_D;
        else if (w_gnt_i) r_last_grant <= GNT_I;
        else if (w_gnt_d) r_last_grant <= GNT_D;
    end

    l1_l2_arb_req_reg #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_gnt_i | w_gnt_d),
        .i_clear (w_clear),
        .i_rd    (w_ld_rd),
        .i_wr    (w_ld_wr),
        .i_addr  (w_ld_addr),
        .i_wdata (w_ld_wdata),
        .i_mbe   (w_ld_mbe),
        .o_rd    (w_rd),
        .o_wr    (w_wr),
        .o_addr  (w_addr),
        .o_wdata (w_wdata),
        .o_mbe   (w_mbe)
    );

    assign bus.l2_read  = ~w_idle & w_rd;
    assign bus.l2_write = ~w_idle & w_wr;
    assign bus.l2_addr  = w_addr;
    assign bus.l2_wdata = w_wdata;
    assign bus.l2_mbe   = w_mbe;

    assign bus.i_resp   = (r_state == SERVE_I) & bus.l2_resp;
    assign bus.d_resp   = (r_state == SERVE_D) & bus.l2_resp;
    assign bus.i_rdata  = bus.l2_rdata;
    assign bus.d_rdata  = bus.l2_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed self-checking bench for l1_l2_arbiter.
module tb_l1_l2_arbiter;
    import l1_l2_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] line_c;

    l1_l2_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

    l1_l2_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive point: just after the active edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Sample point: opposite edge.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_read   = 1'b0;
        bus.i_addr   = '0;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.d_mbe    = '0;
        bus.l2_resp  = 1'b0;
        bus.l2_rdata = '0;
    endtask

    task automatic rand_inputs();
        bus.i_read  = 1'($urandom);
        bus.i_addr  = $urandom;
        bus.d_read  = 1'($urandom);
        bus.d_write = 1'($urandom);
        bus.d_addr  = $urandom;
        bus.d_mbe   = $urandom;
        bus.l2_resp = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            bus.d_wdata[k*32 +: 32]  = $urandom;
            bus.l2_rdata[k*32 +: 32] = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rand_inputs();
        adv(); rand_inputs();
        adv(); rand_inputs();
        smp();
        checks++;
        if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000", {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp});
        end
        checks++;
        if (bus.l2_addr !== 32'h0 || bus.l2_wdata !== 256'h0 || bus.l2_mbe !== 32'h0) begin
            errors++;
            $display("FAIL reset_req got addr=%h mbe=%h exp 0", bus.l2_addr, bus.l2_mbe);
        end
        checks++;
        if (dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", dut.r_state, IDLE);
        end
        checks++;
        if (bus.i_rdata !== bus.l2_rdata || bus.d_rdata !== bus.l2_rdata) begin
            errors++;
            $display("FAIL reset_rdata_pass got i=%h exp %h", bus.i_rdata, bus.l2_rdata);
        end
        adv();
        rst = 1'b0;
        idle_inputs();
        smp();
    endtask

    task automatic test_i_only();
        adv();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_1000;
        smp();
        checks++;
        if (bus.l2_read !== 1'b0) begin
            errors++;
            $display("FAIL i_only_cycleN got l2_read=%b exp 0", bus.l2_read);
        end
        adv();
        smp();
        checks++;
        if (bus.l2_read !== 1'b1 || bus.l2_write !== 1'b0 || bus.l2_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL i_only_n1 got rd=%b wr=%b addr=%h exp 1 0 00001000", bus.l2_read, bus.l2_write, bus.l2_addr);
        end
        for (int c = 0; c < 3; c++) begin
            adv();
            smp();
            checks++;
            if (bus.l2_read !== 1'b1 || bus.i_resp !== 1'b0) begin
                errors++;
                $display("FAIL i_only_hold%0d got rd=%b resp=%b exp 1 0", c, bus.l2_read, bus.i_resp);
            end
        end
        adv();
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = line_a;
        smp();
        checks++;
        if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0 || bus.i_rdata !== line_a) begin
            errors++;
            $display("FAIL i_only_resp got i=%b d=%b rdata=%h exp 1 0 %h", bus.i_resp, bus.d_resp, bus.i_rdata, line_a);
        end
        adv();
        idle_inputs();
        smp();
        checks++;
        if (bus.i_resp !== 1'b0 || bus.l2_read !== 1'b0) begin
            errors++;
            $display("FAIL i_only_after got resp=%b rd=%b exp 0 0", bus.i_resp, bus.l2_read);
        end
    endtask

    task automatic test_d_write();
        adv();
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h8000_0040;
        bus.d_mbe   = '1;
        bus.d_wdata = line_b;
        smp();
        for (int c = 0; c < 3; c++) begin
            adv();
            bus.d_wdata = (c % 2 == 0) ? ~line_b : line_c;
            smp();
            checks++;
            if (bus.l2_write !== 1'b1 || bus.l2_read !== 1'b0 || bus.l2_wdata !== line_b ||
                bus.l2_mbe !== 32'hFFFF_FFFF || bus.l2_addr !== 32'h8000_0040) begin
                errors++;
                $display("FAIL d_write_hold%0d got wr=%b rd=%b addr=%h mbe=%h wdata=%h exp 1 0 80000040 ffffffff %h",
                         c, bus.l2_write, bus.l2_read, bus.l2_addr, bus.l2_mbe, bus.l2_wdata, line_b);
            end
        end
        adv();
        bus.l2_resp = 1'b1;
        smp();
        checks++;
        if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin
            errors++;
            $display("FAIL d_write_resp got d=%b i=%b exp 1 0", bus.d_resp, bus.i_resp);
        end
        adv();
        idle_inputs();
        smp();
        checks++;
        if (bus.d_resp !== 1'b0 || bus.l2_write !== 1'b0) begin
            errors++;
            $display("FAIL d_write_after got resp=%b wr=%b exp 0 0", bus.d_resp, bus.l2_write);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr [3];
        logic        exp_is_i [3];
        exp_addr[0] = 32'h0000_0100; exp_is_i[0] = 1'b1;
        exp_addr[1] = 32'h0000_0200; exp_is_i[1] = 1'b0;
        exp_addr[2] = 32'h0000_0100; exp_is_i[2] = 1'b1;
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0100;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0200;
        smp();
        for (int t = 0; t < 3; t++) begin
            adv();
            smp();
            checks++;
            if (bus.l2_read !== 1'b1 || bus.l2_addr !== exp_addr[t]) begin
                errors++;
                $display("FAIL cont_grant%0d got rd=%b addr=%h exp 1 %h", t, bus.l2_read, bus.l2_addr, exp_addr[t]);
            end
            adv();
            bus.l2_resp = 1'b1;
            smp();
            checks++;
            if (bus.i_resp !== exp_is_i[t] || bus.d_resp !== !exp_is_i[t]) begin
                errors++;
                $display("FAIL cont_resp%0d got i=%b d=%b exp %b %b", t, bus.i_resp, bus.d_resp, exp_is_i[t], !exp_is_i[t]);
            end
            adv();
            bus.l2_resp = 1'b0;
            smp();
            checks++;
            if (bus.l2_read !== 1'b0 || bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
                errors++;
                $display("FAIL cont_bubble%0d got rd=%b i=%b d=%b exp 0 0 0", t, bus.l2_read, bus.i_resp, bus.d_resp);
            end
        end
        // The bubble after the third transaction granted D; finish it cleanly.
        adv();
        bus.i_read = 1'b0;
        bus.l2_resp = 1'b1;
        smp();
        checks++;
        if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin
            errors++;
            $display("FAIL cont_tail got d=%b i=%b exp 1 0", bus.d_resp, bus.i_resp);
        end
        adv();
        idle_inputs();
        smp();
    endtask

    task automatic test_mid_service();
        adv();
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_2000;
        smp();
        adv();
        bus.d_addr = 32'hDEAD_0000;
        smp();
        checks++;
        if (bus.l2_addr !== 32'h0000_2000 || bus.l2_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_addr got addr=%h rd=%b exp 00002000 1", bus.l2_addr, bus.l2_read);
        end
        adv();
        bus.d_read = 1'b0;
        smp();
        checks++;
        if (bus.l2_addr !== 32'h0000_2000 || bus.l2_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_drop got addr=%h rd=%b exp 00002000 1", bus.l2_addr, bus.l2_read);
        end
        adv();
        bus.l2_resp = 1'b1;
        smp();
        checks++;
        if (bus.d_resp !== 1'b1) begin
            errors++;
            $display("FAIL mid_resp got d=%b exp 1", bus.d_resp);
        end
        adv();
        idle_inputs();
        smp();
        adv();
        bus.l2_resp = 1'b1;
        smp();
        checks++;
        if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0 || bus.l2_read !== 1'b0) begin
            errors++;
            $display("FAIL stray_resp got i=%b d=%b rd=%b exp 0 0 0", bus.i_resp, bus.d_resp, bus.l2_read);
        end
        adv();
        bus.l2_resp = 1'b0;
        smp();
        checks++;
        if (dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL stray_state got %0d exp %0d", dut.r_state, IDLE);
        end
    endtask

    task automatic test_reset_mid();
        adv();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_3000;
        smp();
        adv();
        smp();
        checks++;
        if (bus.l2_read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got rd=%b exp 1", bus.l2_read);
        end
        adv();
        rst = 1'b1;
        bus.i_read = 1'b0;
        smp();
        adv();
        rst = 1'b0;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_4000;
        smp();
        checks++;
        if (bus.l2_read !== 1'b0 || bus.l2_addr !== 32'h0 || dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL rstmid_idle got rd=%b addr=%h exp 0 00000000", bus.l2_read, bus.l2_addr);
        end
        adv();
        smp();
        checks++;
        if (bus.l2_read !== 1'b1 || bus.l2_addr !== 32'h0000_4000) begin
            errors++;
            $display("FAIL rstmid_fresh got rd=%b addr=%h exp 1 00004000", bus.l2_read, bus.l2_addr);
        end
        adv();
        bus.l2_resp = 1'b1;
        smp();
        checks++;
        if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_resp got d=%b i=%b exp 1 0", bus.d_resp, bus.i_resp);
        end
        adv();
        idle_inputs();
        smp();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        line_a = {8{32'hA1A2_A3A4}};
        line_b = {4{64'h0123_4567_89AB_CDEF}};
        line_c = {8{32'h5A5A_C3C3}};
        idle_inputs();
        test_reset();
        test_i_only();
        test_d_write();
        test_contention();
        test_mid_service();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
